// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector
//  Description : Programmable symbol-sequence detector. A DEPTH-long pattern
//                of SYM_W-bit symbols is held in writable registers; the
//                incoming symbol stream is tracked by a matched-prefix index.
//                A complete match produces a registered one-cycle hit pulse
//                and bumps a saturating hit counter. Overlapping or
//                non-overlapping restart after a match is selectable.
//  Ports       : clk      - clock, rising edge active
//                res      - asynchronous active-high reset
//                s        - input symbol (SYM_W)
//                s_valid  - s consumed on this edge when 1
//                overlap  - 1 = overlapping restart, 0 = non-overlapping
//                pat_we   - pattern write strobe (wins over s_valid)
//                pat_idx  - pattern slot to write (IW)
//                pat_data - pattern symbol to write (SYM_W)
//                cnt_clr  - synchronous clear of hit_cnt
//                state    - matched-prefix length, 0..DEPTH-1 (IW)
//                hit      - one-cycle pulse after a completed match
//                hit_cnt  - saturating match count (CNT_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic [SYM_W-1:0] s,
  input  logic             s_valid,
  input  logic             overlap,
  input  logic             pat_we,
  input  logic [IW-1:0]    pat_idx,
  input  logic [SYM_W-1:0] pat_data,
  input  logic             cnt_clr,
  output logic [IW-1:0]    state,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [IW-1:0]    c_LAST    = IW'(DEPTH - 1);
  localparam logic [IW:0]      c_DEPTH_X = (IW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [SYM_W-1:0] r_pat [DEPTH];
  logic [IW-1:0]    r_state;
  logic             r_hit;
  logic [CNT_W-1:0] r_cnt;

  logic [IW-1:0]    w_state_nxt;
  logic             w_hit_nxt;
  logic             w_eq_cur;
  logic             w_eq_first;
  logic             w_idx_ok;

  // Comparisons always use the pattern as it stood before this edge.
  assign w_eq_cur   = (s == r_pat[r_state]);
  assign w_eq_first = (s == r_pat[0]);
  // Only meaningful when DEPTH is not a power of two.
  assign w_idx_ok   = ({1'b0, pat_idx} < c_DEPTH_X);

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = 1'b0;
    if (pat_we) begin
      // A pattern update invalidates any partial progress.
      w_state_nxt = '0;
    end else if (s_valid) begin
      if (w_eq_cur) begin
        if (r_state == c_LAST) begin
          w_hit_nxt = 1'b1;
          // Overlapping restart lets the completing symbol begin a new match.
          w_state_nxt = (overlap && w_eq_first) ? IW'(1) : '0;
        end else begin
          w_state_nxt = r_state + IW'(1);
        end
      end else begin
        // Mismatch falls back to a single-symbol prefix check only.
        w_state_nxt = w_eq_first ? IW'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pat[i] <= SYM_W'(i + 1);
      end
    end else if (pat_we && w_idx_ok) begin
      r_pat[pat_idx] <= pat_data;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hit   <= w_hit_nxt;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_hit_nxt && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign state   = r_state;
  assign hit     = r_hit;
  assign hit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector
//  Description : Self-checking bench for seq_detector. Two instances share
//                all stimulus: one with an 8-bit hit counter, one with a
//                2-bit counter to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [1:0] s = '0;
  logic       s_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_we = 1'b0;
  logic [1:0] pat_idx = '0;
  logic [1:0] pat_data = '0;
  logic       cnt_clr = 1'b0;

  logic [1:0] st_a, st_b;
  logic       hit_a, hit_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pat [DEPTH];
  int m_state;
  int m_hit;
  int m_cnt8;
  int m_cnt2;

  seq_detector #(.SYM_W(2), .DEPTH(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .res(res), .s(s), .s_valid(s_valid), .overlap(overlap),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_data(pat_data),
    .cnt_clr(cnt_clr), .state(st_a), .hit(hit_a), .hit_cnt(cnt_a)
  );

  seq_detector #(.SYM_W(2), .DEPTH(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .res(res), .s(s), .s_valid(s_valid), .overlap(overlap),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_data(pat_data),
    .cnt_clr(cnt_clr), .state(st_b), .hit(hit_b), .hit_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state_a"}, int'(st_a), m_state);
    chk({tag, ".state_b"}, int'(st_b), m_state);
    chk({tag, ".hit_a"}, int'(hit_a), m_hit);
    chk({tag, ".hit_b"}, int'(hit_b), m_hit);
    chk({tag, ".cnt8"}, int'(cnt_a), m_cnt8);
    chk({tag, ".cnt2"}, int'(cnt_b), m_cnt2);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_pat[i] = (i + 1) % 4;
    m_state = 0;
    m_hit   = 0;
    m_cnt8  = 0;
    m_cnt2  = 0;
  endfunction

  // Apply one clock edge's worth of rules to the model.
  function automatic void model_edge(int v, int sym, int ov, int we,
                                     int idx, int dat, int clr);
    int matched;
    matched = 0;
    if (we != 0) begin
      if (idx < DEPTH) m_pat[idx] = dat;
      m_state = 0;
    end else if (v != 0) begin
      if (sym == m_pat[m_state] && m_state == DEPTH - 1) begin
        matched = 1;
        m_state = (ov != 0 && sym == m_pat[0]) ? 1 : 0;
      end else if (sym == m_pat[m_state]) begin
        m_state = m_state + 1;
      end else begin
        m_state = (sym == m_pat[0]) ? 1 : 0;
      end
    end
    m_hit = matched;
    if (clr != 0) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (matched != 0) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endfunction

  task automatic step(input string tag, input int v, input int sym,
                      input int ov, input int we, input int idx,
                      input int dat, input int clr);
    @(negedge clk);
    s_valid  = v[0];
    s        = sym[1:0];
    overlap  = ov[0];
    pat_we   = we[0];
    pat_idx  = idx[1:0];
    pat_data = dat[1:0];
    cnt_clr  = clr[0];
    model_edge(v, sym, ov, we, idx, dat, clr);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic sym_in(input string tag, input int sym, input int ov);
    step(tag, 1, sym, ov, 0, 0, 0, 0);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pulse reset between clock edges and check it takes effect at once.
  task automatic async_reset(input string tag);
    @(negedge clk);
    s_valid = 1'b0;
    pat_we  = 1'b0;
    cnt_clr = 1'b0;
    #2;
    res = 1'b1;
    #1;
    model_reset();
    chk_all(tag);
    #1;
    res = 1'b0;
  endtask

  initial begin
    // Power-up reset
    res = 1'b1;
    #2;
    model_reset();
    chk_all("reset");
    #2;
    res = 1'b0;

    // Default pattern 1,2,3,0
    sym_in("d1", 1, 0);
    sym_in("d2", 2, 0);
    sym_in("d3", 3, 0);
    sym_in("d4", 0, 0);
    idle("d_after");

    // Repeated first symbol falls back to a one-symbol prefix
    sym_in("r1", 1, 0);
    sym_in("r2", 1, 0);
    sym_in("r3", 2, 0);
    sym_in("r4", 3, 0);
    sym_in("r5", 0, 0);
    sym_in("r6", 2, 0);

    // Pattern 1,1,1,1: non-overlapping then overlapping runs of eight 1s
    for (int i = 0; i < DEPTH; i++) step("wr1111", 0, 0, 0, 1, i, 1, 0);
    for (int i = 0; i < 8; i++) sym_in("ov0", 1, 0);
    idle("ov0_gap");
    step("ov_sync", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) sym_in("ov1", 1, 1);
    idle("ov1_gap");

    // Back to defaults; write wins over a simultaneous symbol mid-match
    async_reset("rst2");
    sym_in("w1", 1, 0);
    sym_in("w2", 2, 0);
    step("w_we", 1, 3, 0, 1, 2, 0, 0);
    // Pattern now 1,2,0,0; run it with 3-cycle s_valid gaps
    sym_in("g1", 1, 0);
    repeat (3) idle("g1_gap");
    sym_in("g2", 2, 0);
    repeat (3) idle("g2_gap");
    sym_in("g3", 0, 0);
    repeat (3) idle("g3_gap");
    sym_in("g4", 0, 0);
    idle("g4_after");

    // Five matches of 1,2,0,0: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      sym_in("sat_a", 1, 0);
      sym_in("sat_b", 2, 0);
      sym_in("sat_c", 0, 0);
      sym_in("sat_d", 0, 0);
    end
    // Clear coincident with a match: count 0 and hit 1
    sym_in("clr_a", 1, 0);
    sym_in("clr_b", 2, 0);
    sym_in("clr_c", 0, 0);
    step("clr_hit", 1, 0, 0, 0, 0, 0, 1);

    // Async reset at state 3 discards progress and restores the pattern
    async_reset("rst3");
    sym_in("m1", 1, 0);
    sym_in("m2", 2, 0);
    sym_in("m3", 3, 0);
    async_reset("rst_mid");
    sym_in("m_after", 0, 0);
    sym_in("m_chk1", 1, 0);
    sym_in("m_chk2", 2, 0);
    sym_in("m_chk3", 3, 0);
    sym_in("m_chk4", 0, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int v, sym, ov, we, idx, dat, clr;
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sym = $urandom_range(0, 3);
      ov  = $urandom_range(0, 1);
      we  = ($urandom_range(0, 39) == 0) ? 1 : 0;
      idx = $urandom_range(0, 3);
      dat = $urandom_range(0, 3);
      clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
      // Bias symbols toward the current pattern so matches actually occur
      if ($urandom_range(0, 2) != 0) sym = m_pat[m_state];
      step("rand", v, sym, ov, we, idx, dat, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
